// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed by a small byte FIFO.
// The bit period is latched per frame, and queued frames go out back to back.
module uart_tx_buffered #(
  parameter int FifoDepth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [14:0]                clks_per_bit_i,
  input  logic                       tx_valid_i,
  input  logic [7:0]                 tx_byte_i,
  output logic                       tx_ready_o,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(FifoDepth):0] fifo_level_o
);
  localparam int AW = $clog2(FifoDepth);
  localparam int PW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    mem_reg [FifoDepth];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;

  logic [1:0]    state_reg;
  logic [7:0]    shift_reg;
  logic [14:0]   period_reg;
  logic [14:0]   baud_reg;
  logic [2:0]    bit_idx_reg;
  logic          tx_reg;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          bit_end;
  logic [14:0]   period_next;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);

  assign push        = tx_valid_i && !fifo_full;
  assign bit_end     = (baud_reg == period_reg - 15'd1);
  assign pop         = !fifo_empty &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_end));
  assign period_next = (clks_per_bit_i == 15'd0) ? 15'd1 : clks_per_bit_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= tx_byte_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= ST_IDLE;
      tx_reg      <= 1'b1;
      shift_reg   <= '0;
      period_reg  <= 15'd1;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
    end else if (pop) begin
      // Reached from IDLE or from the last STOP cycle; both start a new frame.
      state_reg   <= ST_START;
      tx_reg      <= 1'b0;
      shift_reg   <= mem_reg[rd_ptr_reg[AW-1:0]];
      period_reg  <= period_next;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
        end
        ST_START: begin
          if (bit_end) begin
            baud_reg  <= '0;
            state_reg <= ST_DATA;
            tx_reg    <= shift_reg[0];
          end else begin
            baud_reg <= baud_reg + 15'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_reg    <= '0;
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
              tx_reg    <= 1'b1;
            end else begin
              tx_reg <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 15'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_reg  <= '0;
            state_reg <= ST_IDLE;
            tx_reg    <= 1'b1;
          end else begin
            baud_reg <= baud_reg + 15'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o         = tx_reg;
  assign tx_ready_o   = !fifo_full;
  assign busy_o       = (state_reg != ST_IDLE) || !fifo_empty;
  assign done_o       = (state_reg == ST_STOP) && bit_end;
  assign fifo_level_o = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: pushes directed bytes and decodes the serial line
// against a queue of expected frames (byte plus expected bit period).
module tb_uart_tx_buffered;
  localparam int FifoDepth = 4;

  logic                       clk;
  logic                       rst_ni;
  logic [14:0]                cpb;
  logic                       tx_valid;
  logic [7:0]                 tx_byte;
  logic                       tx_ready;
  logic                       tx_line;
  logic                       busy;
  logic                       done;
  logic [$clog2(FifoDepth):0] level;

  typedef struct {
    logic [7:0] data;
    int         c;
  } exp_t;

  exp_t exp_q[$];

  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;
  int  pushes     = 0;
  int  starts     = 0;
  int  done_cnt   = 0;
  int  last_fall  = 0;
  int  last_done  = 0;
  int  prev_done  = 0;
  bit  mon_active = 0;

  uart_tx_buffered #(.FifoDepth(FifoDepth)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .clks_per_bit_i(cpb),
    .tx_valid_i    (tx_valid),
    .tx_byte_i     (tx_byte),
    .tx_ready_o    (tx_ready),
    .tx_o          (tx_line),
    .busy_o        (busy),
    .done_o        (done),
    .fifo_level_o  (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decodes each frame cycle by cycle and checks line level, bit timing,
  // the done pulse position and the FIFO level model.
  initial begin : monitor
    exp_t       e;
    logic [9:0] bits;
    int         k;
    int         bit_err;
    int         done_err;
    e = '{data: 8'h00, c: 1};
    bits = '0; k = 0; bit_err = 0; done_err = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        mon_active = 0;
        continue;
      end
      if (done) done_cnt++;
      if (!mon_active && done) begin
        compared++;
        mismatched++;
        $display("FAIL done_outside_frame: got 1, expected 0 (cycle %0d)", cyc);
      end
      if (!mon_active && tx_line == 1'b0) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_frame: line low with no byte queued (cycle %0d)", cyc);
        end else begin
          e          = exp_q.pop_front();
          bits       = {1'b1, e.data, 1'b0};
          k          = 0;
          bit_err    = 0;
          done_err   = 0;
          mon_active = 1;
          starts++;
          last_fall  = cyc;
        end
      end
      chk("fifo_level", int'(level), pushes - starts);
      if (mon_active) begin
        if (tx_line !== bits[k / e.c]) bit_err++;
        if (done !== (k == 10 * e.c - 1)) done_err++;
        k++;
        if (k == 10 * e.c) begin
          compared++;
          if (bit_err != 0) begin
            mismatched++;
            $display("FAIL frame: byte %02h at C=%0d had %0d wrong line cycles, expected 0",
                     e.data, e.c, bit_err);
          end
          compared++;
          if (done_err != 0) begin
            mismatched++;
            $display("FAIL done_timing: byte %02h had %0d wrong done cycles, expected 0",
                     e.data, done_err);
          end
          $display("frame byte=%02h C=%0d fall=%0d done=%0d", e.data, e.c, last_fall, cyc);
          mon_active = 0;
          prev_done  = last_done;
          last_done  = cyc;
        end
      end
    end
  end

  // Called at posedge+1; holds valid until accepted, then records the expectation.
  task automatic push_byte(input logic [7:0] b, input int c_exp, output int acc_cyc);
    bit ok;
    ok       = 1'b0;
    tx_byte  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      ok = tx_ready;
      @(posedge clk);
      #1;
    end
    acc_cyc = cyc;
    if (!ok) begin
      chk("push_timeout", 0, 1);
    end else begin
      exp_q.push_back('{data: b, c: c_exp});
      pushes++;
      $display("push byte=%02h C=%0d cycle=%0d", b, c_exp, cyc);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || mon_active) && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= max_cycles) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    pushes = starts;
    rst_ni = 1'b1;
  endtask

  initial begin : stim
    int acc;
    int acc5;
    int acc6;
    int d0;
    int low_cnt;
    logic [7:0] wrap_data [13];
    wrap_data = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'hFF,
                  8'h00, 8'h7E, 8'h81, 8'h12, 8'h34, 8'h56};
    rst_ni   = 1'b0;
    cpb      = 15'd4;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx_line, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_level", int'(level), 0);
    @(posedge clk);
    #1;

    // Single byte, C=4
    cpb = 15'd4;
    d0  = done_cnt;
    push_byte(8'hA5, 4, acc);
    wait_idle(400);
    chk("single_latency", last_fall - acc, 1);
    chk("single_frame_len", last_done - last_fall, 39);
    chk("single_done_count", done_cnt - d0, 1);
    chk("single_busy_after", busy, 0);

    // Back to back, C=2
    cpb = 15'd2;
    d0  = done_cnt;
    push_byte(8'h00, 2, acc);
    push_byte(8'hFF, 2, acc);
    wait_idle(400);
    chk("b2b_done_spacing", last_done - prev_done, 20);
    chk("b2b_no_gap", last_fall - prev_done, 1);
    chk("b2b_done_count", done_cnt - d0, 2);

    // FIFO full, C=8, valid held across bytes 1..6
    cpb  = 15'd8;
    d0   = done_cnt;
    acc5 = 0;
    for (int b = 1; b <= 5; b++) begin
      push_byte(8'(b), 8, acc5);
      tx_valid = 1'b1;
    end
    chk("full_level", int'(level), 4);
    chk("full_ready", tx_ready, 0);
    push_byte(8'h06, 8, acc6);
    chk("full_stall_cycles", acc6 - acc5, 78);
    wait_idle(1000);
    chk("full_done_count", done_cnt - d0, 6);

    // Reset during DATA bit 3 with two bytes still queued
    cpb = 15'd4;
    push_byte(8'h3C, 4, acc);
    push_byte(8'h11, 4, acc);
    push_byte(8'h22, 4, acc);
    while (cyc < last_fall + 17) begin
      @(posedge clk);
      #1;
    end
    chk("mid_bit3_line", tx_line, 1);
    chk("mid_level", int'(level), 2);
    d0 = done_cnt;
    do_reset();
    @(negedge clk);
    chk("post_rst_tx", tx_line, 1);
    chk("post_rst_level", int'(level), 0);
    chk("post_rst_done", done, 0);
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_line == 1'b0) low_cnt++;
    end
    chk("post_rst_low_cycles", low_cnt, 0);
    chk("post_rst_done_count", done_cnt - d0, 0);
    chk("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;

    // Period 0 acts as 1; then period change mid-frame is ignored
    cpb = 15'd0;
    push_byte(8'h55, 1, acc);
    wait_idle(200);
    chk("c0_frame_len", last_done - last_fall, 9);
    cpb = 15'd3;
    push_byte(8'h55, 3, acc);
    repeat (5) @(posedge clk);
    #1;
    cpb = 15'd9;
    wait_idle(400);
    chk("c3_frame_len", last_done - last_fall, 29);

    // Wrap-around: 3*FifoDepth+1 bytes with random gaps
    cpb = 15'd2;
    d0  = done_cnt;
    for (int i = 0; i < 3 * FifoDepth + 1; i++) begin
      repeat ($urandom_range(0, 15)) @(posedge clk);
      #1;
      push_byte(wrap_data[i], 2, acc);
    end
    wait_idle(3000);
    chk("wrap_done_count", done_cnt - d0, 3 * FifoDepth + 1);
    chk("wrap_level_end", int'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

UART transmitter with a small input byte FIFO, the send-side counterpart of the `uart_rx` programmer path in the SoC top. It sends 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) on a single serial line. The bit period is set at run time in clock cycles, using the same encoding as `uart_rx`. Typical uses are the programming/debug console and status reporting from the ICCM loader.

## Interface
- `FifoDepth`, default 4: depth of the byte FIFO. Must be a power of two and ≥ 2.
- `clk_i`  in  1: the single clock; all logic is on its rising edge.
- `rst_ni`  in  1: synchronous, active-low reset.
- `clks_per_bit_i`  in  15: bit period in clock cycles. A value of 0 is treated as 1.
- `tx_valid_i`  in  1: the byte on `tx_byte_i` is offered for transmission.
- `tx_byte_i`  in  8: data byte to send.
- `tx_ready_o`  out  1: the FIFO can accept a byte. Equal to !full.
- `tx_o`  out  1: serial output, registered. Idle level is 1.
- `busy_o`  out  1: the FSM is not in IDLE, or the FIFO is not empty.
- `done_o`  out  1: one-cycle pulse at the end of each frame's stop bit.
- `fifo_level_o`  out  $clog2(FifoDepth)+1: number of bytes currently held in the FIFO.

## Operation
- **Push.** A byte is written into the FIFO on any edge where `tx_valid_i && tx_ready_o`. When the FIFO is full, `tx_valid_i` is ignored and no data is lost or overwritten.
- **FSM states.** IDLE, START, DATA, STOP.
- **IDLE.**
  - `tx_o` = 1.
  - If the FIFO is non-empty: pop the head byte into an 8-bit shift register, latch `clks_per_bit_i` (0 becomes 1) into the period register C, clear the baud counter and the bit index, and go to START.
- **START.**
  - `tx_o` = 0 for C cycles, then go to DATA.
- **DATA.**
  - `tx_o` = shift[0] for C cycles, then shift right and increment the bit index.
  - After the bit with index 7, go to STOP.
- **STOP.**
  - `tx_o` = 1 for C cycles.
  - On the last cycle, pulse `done_o`.
  - If the FIFO is non-empty on that edge, pop the next byte, re-latch C and go straight to START, so frames go out back to back with no idle gap.
  - Otherwise go to IDLE.
- **Baud counter.** 15 bits wide, counts 0..C-1. A bit ends on the edge where the counter equals C-1.
- **Push and pop on the same edge.** Both take effect and `fifo_level_o` is unchanged.
  - Pushing into an empty FIFO on the same edge as an idle pop check does not bypass the FIFO. That byte is popped at the following edge.
- **Pointers.** Read/write pointers are $clog2(FifoDepth)+1 bits and wrap naturally.
  - full = MSBs differ and lower bits are equal.
  - empty = pointers equal.
- **Period change.** Changing `clks_per_bit_i` mid-frame has no effect until the next pop.
- **Reset.** Reset asserted at any point, including mid-frame, does the following at that edge:
  - flushes the FIFO (level 0)
  - returns the FSM to IDLE
  - drives `tx_o` = 1 from the next cycle
  - no partial frame resumes after reset.

## Timing
- **Reset values.**
  - `tx_o` = 1
  - `tx_ready_o` = 1
  - `busy_o` = 0
  - `done_o` = 0
  - `fifo_level_o` = 0
- **Latency.** Accept edge E0 (FIFO empty, FSM IDLE) → pop at edge E1 → `tx_o` falls in the cycle after E1.
- **Frame length.** Exactly 10·C cycles from the falling edge of the start bit to the `done_o` pulse.
  - `done_o` is high during the final cycle of the stop bit.
- **Output timing.** `tx_o` is driven from a flop and has no combinational path from any input.
- **`tx_ready_o`.** Purely a function of the registered pointers. It deasserts in the cycle after the push that fills the FIFO.
- **`busy_o`.** Falls in the cycle after the last STOP→IDLE edge.

## Test plan
- **Single byte.** Reset, C=4, push 0xA5.
  - `tx_o` must show 0,1,0,1,0,0,1,0,1,1, each level held for 4 cycles, starting 2 cycles after the accept.
  - `done_o` pulses once, 40 cycles after the start-bit fall.
  - `busy_o` then returns to 0.
- **Back to back.** C=2, push 0x00 then 0xFF on consecutive cycles.
  - Two frames, 20 cycles each, with no idle gap: the stop bit of frame 1 is followed directly by the start bit of frame 2.
  - Two `done_o` pulses, 20 cycles apart.
- **FIFO full.** FifoDepth=4, C=8, hold `tx_valid_i`=1 with bytes 1..6 on successive accepts.
  - Byte 1 is popped; bytes 2..5 fill the FIFO; `tx_ready_o`=0 with `fifo_level_o`=4.
  - Byte 6 stalls until byte 2 is popped at the end of frame 1.
  - The line carries 1..6 in order with none lost.
- **Reset mid-frame.** With C=4, assert `rst_ni`=0 for 1 cycle during DATA bit 3, with 2 bytes still queued.
  - `tx_o` = 1 from the next cycle, `fifo_level_o` = 0, and no `done_o` pulse.
  - No further frames are sent.
- **Period edge cases.** `clks_per_bit_i`=0, push 0x55.
  - Frame of 10 cycles, 1 cycle per bit.
  - Then set C=3 and push 0x55, and change `clks_per_bit_i` to 9 mid-frame: that frame still uses 3 cycles per bit (30 cycles total).
- **Wrap-around.** Push and transmit 3·FifoDepth+1 bytes with random gaps.
  - Every byte is received in order, and `fifo_level_o` always equals pushes minus pops.
